// File: rtl/bin_to_bcd_display.sv
// bin_to_bcd_display: double-dabble binary to 3-digit BCD with seven-segment outputs; optional BCD_LEADING_ZERO_BLANK_EN blanks leading zeros
module bin_to_bcd_display #(
  parameter int IN_W = 8,
  parameter bit SEG_ACTIVE_LOW = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [IN_W-1:0] Y_in,
  output logic            busy,
  output logic            valid,
  output logic [11:0]     bcd,
  output logic [6:0]      hex0,
  output logic [6:0]      hex1,
  output logic [6:0]      hex2
);
  localparam int CW = $clog2(IN_W + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(IN_W);
  localparam logic [6:0] SEG_ZERO = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
`ifdef BCD_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] SEG_LEAD_RST = SEG_BLANK;
`else
  localparam logic [6:0] SEG_LEAD_RST = SEG_ZERO;
`endif
  typedef enum logic [1:0] {ST_IDLE, ST_ADJUST, ST_SHIFT, ST_DONE} state_t;
  state_t state_q, state_d;
  logic [IN_W-1:0] bin_sr_q, bin_sr_d;
  logic [11:0] scratch_q, scratch_d, bcd_q, bcd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic valid_q, valid_d;
  logic [6:0] hex0_q, hex0_d, hex1_q, hex1_d, hex2_q, hex2_d;
  function automatic logic [6:0] seg(input logic [3:0] n);
    case (n)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = 7'b0111111;
    endcase
  endfunction
  function automatic logic [6:0] pol(input logic [6:0] s);
    pol = SEG_ACTIVE_LOW ? s : ~s;
  endfunction
  function automatic logic [3:0] adj(input logic [3:0] n);
    adj = (n >= 4'd5) ? n + 4'd3 : n;
  endfunction
  assign busy = state_q != ST_IDLE;
  assign valid = valid_q;
  assign bcd = bcd_q;
  assign hex0 = hex0_q;
  assign hex1 = hex1_q;
  assign hex2 = hex2_q;
  // Next-state logic: accept a load in idle, then alternate adjust/shift IN_W times and publish
  always_comb begin
    state_d = state_q;
    bin_sr_d = bin_sr_q;
    scratch_d = scratch_q;
    cnt_d = cnt_q;
    bcd_d = bcd_q;
    hex0_d = hex0_q;
    hex1_d = hex1_q;
    hex2_d = hex2_q;
    valid_d = 1'b0;
    case (state_q)
      ST_IDLE: if (load) begin
        bin_sr_d = Y_in;
        scratch_d = '0;
        cnt_d = '0;
        state_d = ST_ADJUST;
      end
      ST_ADJUST: begin
        scratch_d = {adj(scratch_q[11:8]), adj(scratch_q[7:4]), adj(scratch_q[3:0])};
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        {scratch_d, bin_sr_d} = {scratch_q, bin_sr_q} << 1;
        cnt_d = cnt_q + CW'(1);
        state_d = (cnt_d == CNT_LAST) ? ST_DONE : ST_ADJUST;
      end
      ST_DONE: begin
        bcd_d = scratch_q;
        hex0_d = pol(seg(scratch_q[3:0]));
`ifdef BCD_LEADING_ZERO_BLANK_EN
        hex1_d = pol(scratch_q[11:4] == 8'd0 ? SEG_BLANK : seg(scratch_q[7:4]));
        hex2_d = pol(scratch_q[11:8] == 4'd0 ? SEG_BLANK : seg(scratch_q[11:8]));
`else
        hex1_d = pol(seg(scratch_q[7:4]));
        hex2_d = pol(seg(scratch_q[11:8]));
`endif
        valid_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  // State registers with synchronous active-low reset that discards any conversion in flight
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      bin_sr_q <= '0;
      scratch_q <= '0;
      cnt_q <= '0;
      bcd_q <= '0;
      valid_q <= 1'b0;
      hex0_q <= pol(SEG_ZERO);
      hex1_q <= pol(SEG_LEAD_RST);
      hex2_q <= pol(SEG_LEAD_RST);
    end else begin
      state_q <= state_d;
      bin_sr_q <= bin_sr_d;
      scratch_q <= scratch_d;
      cnt_q <= cnt_d;
      bcd_q <= bcd_d;
      valid_q <= valid_d;
      hex0_q <= hex0_d;
      hex1_q <= hex1_d;
      hex2_q <= hex2_d;
    end
  end
endmodule

// File: tb/tb_bin_to_bcd_display.sv
// tb_bin_to_bcd_display: directed self-checking bench for bin_to_bcd_display
module tb_bin_to_bcd_display;
  logic clk = 1'b0, rst = 1'b0, load = 1'b0;
  logic [7:0] Y_in = '0;
  logic busy, valid;
  logic [11:0] bcd;
  logic [6:0] hex0, hex1, hex2;
  int n_checks = 0, n_fail = 0;
`ifdef BCD_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = 7'h7F;
`else
  localparam logic [6:0] LZ = 7'h40;
`endif
  bin_to_bcd_display dut (
    .clk(clk), .rst(rst), .load(load), .Y_in(Y_in), .busy(busy), .valid(valid),
    .bcd(bcd), .hex0(hex0), .hex1(hex1), .hex2(hex2)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wait_valid(input int ign_at, output int t, output int nb);
    t = 0;
    nb = 0;
    do begin
      if (ign_at >= 0) begin
        load = (t == ign_at);
        if (t == ign_at) Y_in = 8'd7;
      end
      tick;
      t++;
      if (busy) nb++;
    end while (!valid && t < 40);
  endtask
  task automatic run(input logic [7:0] y, input logic [11:0] eb, input logic [6:0] e2, input logic [6:0] e1,
                     input logic [6:0] e0, input int ign_at);
    int t, nb;
    load = 1'b1;
    Y_in = y;
    tick;
    load = 1'b0;
    check("busy_start", busy, 1);
    wait_valid(ign_at, t, nb);
    check("latency", t, 17);
    check("busy_cycles", nb + 1, 17);
    check("bcd", bcd, eb);
    check("hex2", hex2, e2);
    check("hex1", hex1, e1);
    check("hex0", hex0, e0);
    tick;
    check("valid_single", valid, 0);
    check("idle_after", busy, 0);
  endtask
  initial begin
    int t, nb, nv;
    tick;
    tick;
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_bcd", bcd, 0);
    check("rst_hex2", hex2, LZ);
    check("rst_hex1", hex1, LZ);
    check("rst_hex0", hex0, 7'h40);
    rst = 1'b1;
    tick;
    run(8'd225, 12'h225, 7'h24, 7'h24, 7'h12, -1);
    run(8'd0, 12'h000, LZ, LZ, 7'h40, -1);
    run(8'd99, 12'h099, LZ, 7'h10, 7'h10, -1);
    run(8'd42, 12'h042, LZ, 7'h19, 7'h24, 5);
    load = 1'b1;
    Y_in = 8'd200;
    tick;
    load = 1'b0;
    repeat (7) tick;
    rst = 1'b0;
    tick;
    check("abort_busy", busy, 0);
    check("abort_bcd", bcd, 0);
    check("abort_valid", valid, 0);
    rst = 1'b1;
    nv = 0;
    repeat (20) begin
      tick;
      if (valid) nv++;
    end
    check("abort_no_valid", nv, 0);
    run(8'd1, 12'h001, LZ, LZ, 7'h79, -1);
    load = 1'b1;
    Y_in = 8'd128;
    tick;
    wait_valid(-1, t, nb);
    check("hold_first_lat", t, 17);
    check("hold_bcd0", bcd, 12'h128);
    check("hold_hex2", hex2, 7'h79);
    check("hold_hex1", hex1, 7'h24);
    check("hold_hex0", hex0, 7'h00);
    for (int i = 0; i < 2; i++) begin
      wait_valid(-1, t, nb);
      check("hold_spacing", t, 18);
      check("hold_bcd", bcd, 12'h128);
    end
    load = 1'b0;
    nv = 0;
    while (busy && nv < 40) begin
      tick;
      nv++;
    end
    check("hold_drain", busy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/bin_to_bcd_display.md
Name: bin_to_bcd_display

Overview:
- Downstream stage of the 4x4 shift-add multiplier on the DE10-Lite.
- Captures the 8-bit product when the multiplier's one-cycle done pulse arrives.
- Converts the product to three BCD digits with a sequential double-dabble FSM.
- Holds the result on three active-low seven-segment displays (HEX2..HEX0) until the next conversion.

Parameters:
- IN_W, 8, binary input width; legal range 4..8; iteration count = IN_W.
- SEG_ACTIVE_LOW, 1, 1 = segment outputs active-low (DE10-Lite); 0 = outputs inverted to active-high.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset.
- load  input  1  start request; wired to multiplier done; sampled only in ST_IDLE.
- Y_in  input  IN_W  binary value to convert (multiplier Y), sampled on the accepted load edge.
- busy  output  1  high while state != ST_IDLE; combinational from state register.
- valid  output  1  registered one-cycle pulse: new bcd/hex values valid this cycle.
- bcd  output  12  {hundreds, tens, ones} nibbles; held until next completion.
- hex0  output  7  ones digit, segments {g,f,e,d,c,b,a}.
- hex1  output  7  tens digit, same encoding.
- hex2  output  7  hundreds digit, same encoding.

Behaviour:
- Reset (rst == 0 at a clock edge):
  - state = ST_IDLE; bin_sr, scratch and iteration count = 0.
  - bcd = 0; valid = 0.
  - hex0..hex2 show "0": 7'b1000000 active-low.
  - Reset overrides everything, including an in-flight conversion: the partial result is discarded and no valid pulse is produced.
- States: ST_IDLE, ST_ADJUST, ST_SHIFT, ST_DONE. Unused encodings return to ST_IDLE.
- ST_IDLE:
  - If load == 1: bin_sr <= Y_in, scratch <= 0, cnt <= 0, go to ST_ADJUST.
  - Otherwise stay in ST_IDLE.
- ST_ADJUST: each scratch nibble >= 5 gets +3, nibbles evaluated in parallel; go to ST_SHIFT.
- ST_SHIFT:
  - {scratch, bin_sr} shifted left one bit; cnt <= cnt + 1.
  - If the new cnt == IN_W, go to ST_DONE; else go to ST_ADJUST.
- ST_DONE: bcd <= scratch; hex0..hex2 <= decode(scratch); valid <= 1; go to ST_IDLE.
- valid is 0 in every cycle other than the one following ST_DONE.
- Latency:
  - Load sampled at edge k; valid high in the cycle after edge k + 2*IN_W + 1 (edge k+17 for IN_W = 8).
  - busy is high in the cycles following edges k .. k+2*IN_W.
- load outside ST_IDLE (ST_ADJUST, ST_SHIFT or ST_DONE) is ignored, with no queuing. Y_in changes during a conversion have no effect.
- load is accepted in the first ST_IDLE cycle, including the cycle in which valid is high. Back-to-back conversions are therefore spaced 2*IN_W + 2 cycles apart.
- Arithmetic:
  - The scratch register is 12 bits wide; maximum input 255 gives 0x255, so no overflow is possible.
  - The adjust add is a 4-bit add per nibble; a nibble never exceeds 9 + 3 before the shift.
- Segment decode, active-low 0..9:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - Nibble values 10..15 are unreachable; they decode to 0111111 (dash).
  - With SEG_ACTIVE_LOW = 0, all patterns are bitwise inverted.
- Outputs hex0..hex2 and bcd are registered, with no combinational path from Y_in.

Optional Feature:
- Macro: BCD_LEADING_ZERO_BLANK_EN.
- Defined:
  - In ST_DONE, hex2 is blanked (all segments off: 7'b1111111 active-low) when the hundreds digit is 0.
  - hex1 is blanked when both hundreds and tens are 0.
  - hex0 always shows its digit.
  - Reset state: hex2 and hex1 blank, hex0 = "0".
  - bcd is unaffected by blanking.
- Not defined: all three digits are always displayed, including leading zeros.

Test Plan:
- Reset, then load = 1 for one cycle with Y_in = 8'd225 (15x15):
  - valid pulses exactly 17 edges after the sampling edge.
  - bcd = 12'h225; hex2 = 0100100, hex1 = 0100100, hex0 = 0010010.
  - busy high for 17 cycles.
- Y_in = 8'd0 -> bcd = 12'h000, all hex = 1000000. With BCD_LEADING_ZERO_BLANK_EN: hex2 = hex1 = 1111111, hex0 = 1000000.
- Y_in = 8'd99 -> bcd = 12'h099; hex1 = hex0 = 0010000. hex2 = 1000000 without the macro, 1111111 with it.
- Load 8'd42, then at cycle 5 pulse load with Y_in = 8'd7 -> second load ignored; single valid pulse with bcd = 12'h042.
- Load 8'd200, drive rst = 0 at cycle 8 -> next cycle: state idle, busy = 0, bcd = 0, no valid pulse. A subsequent load of 8'd1 gives bcd = 12'h001.
- Hold load = 1 continuously with Y_in = 8'd128 -> conversions restart every 18 cycles; each valid shows bcd = 12'h128.
